// File: rtl/heater_ctrl_pkg.sv
// Shared types and defaults for the heater enable ramp / error-clear control slice.
package heater_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, STEP, WAIT} ramp_state_t;
  typedef enum logic {CLR_IDLE, CLR_PULSE} clr_state_t;

  localparam int STEP_CYCLES_DEF = 1024;
  localparam int CLR_CYCLES_DEF  = 4;
  localparam int CNT_W_DEF       = 16;

  // popcount operates on a fixed-width view; callers zero-extend narrower masks
  localparam int POP_MAX = 64;
  localparam int POP_W   = 7;

  function automatic logic [POP_W-1:0] popcount(input logic [POP_MAX-1:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < POP_MAX; i++) c = c + POP_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/heater_clr_seq.sv
// Clear-request path: synchronize GPIO requests, detect rising edges, and issue
// batched fixed-width heater_err_clear pulses.
module heater_clr_seq
  import heater_ctrl_pkg::*;
#(
  parameter int N          = 32,
  parameter int CLR_CYCLES = CLR_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] clear_req,
  output logic [N-1:0] clr_pulse,
  output logic [N-1:0] clr_done,
  output logic         clr_busy
);

  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  logic [N-1:0]  req_s1, req_s2, req_s3, req_rise;
  logic [N-1:0]  pending, active;
  logic [CW-1:0] pulse_cnt;
  clr_state_t    state;
  logic          last_pulse;

  assign last_pulse = (state == CLR_PULSE) && (pulse_cnt == CW'(CLR_CYCLES - 1));
  // Sticky bits are released on the edge that ends the pulse
  assign clr_done   = last_pulse ? active : '0;
  assign clr_busy   = (state != CLR_IDLE) || (pending != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      req_s1    <= '0;
      req_s2    <= '0;
      req_s3    <= '0;
      req_rise  <= '0;
      pending   <= '0;
      active    <= '0;
      clr_pulse <= '0;
      pulse_cnt <= '0;
      state     <= CLR_IDLE;
    end else begin
      req_s1   <= clear_req;
      req_s2   <= req_s1;
      req_s3   <= req_s2;
      req_rise <= req_s2 & ~req_s3;
      case (state)
        CLR_IDLE: begin
          if (pending != '0) begin
            active    <= pending;
            clr_pulse <= pending;
            pending   <= req_rise;
            pulse_cnt <= '0;
            state     <= CLR_PULSE;
          end else begin
            pending <= pending | req_rise;
          end
        end
        CLR_PULSE: begin
          pending <= pending | req_rise;
          if (last_pulse) begin
            clr_pulse <= '0;
            state     <= CLR_IDLE;
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end
        default: state <= CLR_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/heater_ramp_ctrl.sv
// Rate-limited heater enable ramp with fault latching, saturating error count,
// and a timed error-clear sequencer.
module heater_ramp_ctrl
  import heater_ctrl_pkg::*;
#(
  parameter int N           = 32,
  parameter int STEP_CYCLES = STEP_CYCLES_DEF,
  parameter int CLR_CYCLES  = CLR_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     target_enable,
  input  logic [N-1:0]     clear_req,
  input  logic [N-1:0]     heater_error,
  output logic [N-1:0]     heater_enable,
  output logic [N-1:0]     heater_err_clear,
  output logic [N-1:0]     err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic             busy
);

  localparam int TW = $clog2(STEP_CYCLES);
  localparam int SW = CNT_W + POP_W;

  logic [N-1:0]  tgt_s1, tgt_sync;
  logic [N-1:0]  err_q, err_qq, err_rise;
  logic [N-1:0]  eff, rem_mask, add_mask, step_bit, clr_done;
  logic [TW-1:0] timer;
  logic [SW-1:0] cnt_sum;
  ramp_state_t   state;
  logic          mismatch, clr_busy;

  heater_clr_seq #(.N(N), .CLR_CYCLES(CLR_CYCLES)) u_clr_seq (
    .clk       (clk),
    .reset     (reset),
    .clear_req (clear_req),
    .clr_pulse (heater_err_clear),
    .clr_done  (clr_done),
    .clr_busy  (clr_busy)
  );

  assign eff      = tgt_sync & ~err_sticky;
  assign mismatch = (heater_enable != eff);
  assign err_rise = err_q & ~err_qq;
  assign busy     = mismatch | clr_busy;
  assign cnt_sum  = SW'(err_count) + SW'(popcount(POP_MAX'(err_rise)));

  // One-hot of the single bit to flip: highest removal first, else lowest addition
  always_comb begin
    rem_mask = heater_enable & ~eff;
    add_mask = eff & ~heater_enable;
    step_bit = '0;
    if (rem_mask != '0) begin
      for (int i = 0; i < N; i++)
        if (rem_mask[i]) begin
          step_bit    = '0;
          step_bit[i] = 1'b1;
        end
    end else begin
      for (int i = N - 1; i >= 0; i--)
        if (add_mask[i]) begin
          step_bit    = '0;
          step_bit[i] = 1'b1;
        end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_s1        <= '0;
      tgt_sync      <= '0;
      err_q         <= '0;
      err_qq        <= '0;
      err_sticky    <= '0;
      err_count     <= '0;
      heater_enable <= '0;
      timer         <= '0;
      state         <= IDLE;
    end else begin
      tgt_s1     <= target_enable;
      tgt_sync   <= tgt_s1;
      err_q      <= heater_error;
      err_qq     <= err_q;
      err_sticky <= (err_sticky & ~clr_done) | err_rise;
      err_count  <= (cnt_sum[SW-1:CNT_W] != '0) ? '1 : cnt_sum[CNT_W-1:0];
      // Faults drop their enable immediately, independent of the ramp timer
      heater_enable <= heater_enable & ~err_rise;
      case (state)
        IDLE: if (mismatch && timer == '0) state <= STEP;
        STEP: begin
          if (mismatch) begin
            heater_enable <= (heater_enable ^ step_bit) & ~err_rise;
            timer         <= TW'(STEP_CYCLES - 1);
            state         <= WAIT;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          timer <= timer - 1'b1;
          // Leave one cycle early so the next change lands exactly STEP_CYCLES apart
          if (timer == TW'(1)) state <= mismatch ? STEP : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
